// File: rtl/rst_seq_pkg.sv
// Shared types, default constants and width helpers for the Kyber reset-domain sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_SOFT    = 2'd3
    } seq_state_e;

    localparam int unsigned NUM_DOMAINS_DEF = 3;
    localparam int unsigned STAGE_DELAY_DEF = 16;
    localparam int unsigned LOCK_FILT_DEF   = 4;
    localparam int unsigned SOFT_HOLD_DEF   = 8;
    localparam int unsigned WDT_CYCLES_DEF  = 1024;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Register width able to hold 0..max_val, never narrower than one bit.
    function automatic int unsigned bits_for(input int unsigned max_val);
        return (max_val == 0) ? 1 : clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rst_sync_filter.sv
// Two-flop synchronizer plus saturating run-length filter for an asynchronous status level.
module rst_sync_filter
    import rst_seq_pkg::*;
#(
    parameter int unsigned FILT = LOCK_FILT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic ok,
    output logic lost
);

    localparam int unsigned CW = bits_for(FILT);

    logic          meta_q;
    logic          sync_q;
    logic          val_q;
    logic          val_nxt;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;

    // Count consecutive equal samples; a changed sample restarts the run at one.
    always_comb begin
        val_nxt = sync_q;
        cnt_nxt = CW'(1);
        if (sync_q == val_q) begin
            cnt_nxt = (cnt_q == CW'(FILT)) ? cnt_q : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            val_q  <= 1'b0;
            cnt_q  <= '0;
            ok     <= 1'b0;
            lost   <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            val_q  <= val_nxt;
            cnt_q  <= cnt_nxt;
            ok     <= val_nxt && (cnt_nxt == CW'(FILT));
            lost   <= !val_nxt && (cnt_nxt == CW'(FILT));
        end
    end

endmodule

// File: rtl/rst_domain_sequencer.sv
// Staged, ordered active-low reset release for the Kyber sub-domains with soft-reset handshake.
// Optional watchdog in RUN is enabled by defining RST_SEQ_WDT_EN.
module rst_domain_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS = NUM_DOMAINS_DEF,
    parameter int unsigned STAGE_DELAY = STAGE_DELAY_DEF,
    parameter int unsigned LOCK_FILT   = LOCK_FILT_DEF,
    parameter int unsigned SOFT_HOLD   = SOFT_HOLD_DEF
`ifdef RST_SEQ_WDT_EN
    ,
    parameter int unsigned WDT_CYCLES  = WDT_CYCLES_DEF
`endif
) (
    input  logic                   FIC_0_CLK,
    input  logic                   RESETN_FIC_0_CLK,
    input  logic                   PLL_LOCK,
    input  logic                   SOFT_RST_REQ,
`ifdef RST_SEQ_WDT_EN
    input  logic                   WDT_KICK,
    output logic                   WDT_EXPIRED,
`endif
    output logic                   SOFT_RST_ACK,
    output logic [NUM_DOMAINS-1:0] DOMAIN_RESETN,
    output logic                   ALL_READY,
    output logic [1:0]             SEQ_STATE
);

    localparam int unsigned IW = bits_for(NUM_DOMAINS - 1);
    localparam int unsigned DW = bits_for(STAGE_DELAY - 1);
    localparam int unsigned HW = bits_for(SOFT_HOLD - 1);

    seq_state_e             state_q,  state_nxt;
    logic [IW-1:0]          stage_q,  stage_nxt;
    logic [DW-1:0]          dly_q,    dly_nxt;
    logic [HW-1:0]          hold_q,   hold_nxt;
    logic [NUM_DOMAINS-1:0] dom_q,    dom_nxt;
    logic                   ack_q,    ack_nxt;
    logic                   rdy_q,    rdy_nxt;
    logic                   rst_meta, rst_sync;
    logic                   lock_ok,  lock_lost;
    logic                   wdt_hit_c;

    // Reset asserts asynchronously, releases through two flops.
    always_ff @(posedge FIC_0_CLK or negedge RESETN_FIC_0_CLK) begin
        if (!RESETN_FIC_0_CLK) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    rst_sync_filter #(
        .FILT (LOCK_FILT)
    ) u_lock_filter (
        .clk      (FIC_0_CLK),
        .rst_n    (RESETN_FIC_0_CLK),
        .async_in (PLL_LOCK),
        .ok       (lock_ok),
        .lost     (lock_lost)
    );

`ifdef RST_SEQ_WDT_EN
    localparam int unsigned WW = bits_for(WDT_CYCLES - 1);

    logic [WW-1:0] wdt_q;
    logic          wdt_exp_q;

    assign wdt_hit_c = (state_q == ST_RUN) && !WDT_KICK && (wdt_q == WW'(WDT_CYCLES - 1));

    always_ff @(posedge FIC_0_CLK or negedge RESETN_FIC_0_CLK) begin
        if (!RESETN_FIC_0_CLK) begin
            wdt_q     <= '0;
            wdt_exp_q <= 1'b0;
        end else begin
            wdt_exp_q <= wdt_hit_c;
            if ((state_q == ST_RUN) && !WDT_KICK && !wdt_hit_c) begin
                wdt_q <= wdt_q + WW'(1);
            end else begin
                wdt_q <= '0;
            end
        end
    end

    assign WDT_EXPIRED = wdt_exp_q;
`else
    assign wdt_hit_c = 1'b0;
`endif

    always_ff @(posedge FIC_0_CLK or negedge RESETN_FIC_0_CLK) begin
        if (!RESETN_FIC_0_CLK) begin
            state_q <= ST_HOLD;
            stage_q <= '0;
            dly_q   <= '0;
            hold_q  <= '0;
            dom_q   <= '0;
            ack_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            stage_q <= stage_nxt;
            dly_q   <= dly_nxt;
            hold_q  <= hold_nxt;
            dom_q   <= dom_nxt;
            ack_q   <= ack_nxt;
            rdy_q   <= rdy_nxt;
        end
    end

    // Lock loss (or watchdog) always wins; each release shifts one more 1 into the thermometer.
    always_comb begin
        state_nxt = state_q;
        stage_nxt = stage_q;
        dly_nxt   = dly_q;
        hold_nxt  = hold_q;
        dom_nxt   = dom_q;
        ack_nxt   = ack_q;
        rdy_nxt   = rdy_q;
        if (!rst_sync || ((state_q != ST_HOLD) && (lock_lost || wdt_hit_c))) begin
            state_nxt = ST_HOLD;
            stage_nxt = '0;
            dly_nxt   = '0;
            dom_nxt   = '0;
            ack_nxt   = 1'b0;
            rdy_nxt   = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (lock_ok) begin
                        state_nxt = ST_RELEASE;
                        stage_nxt = '0;
                        dly_nxt   = '0;
                    end
                end
                ST_RELEASE: begin
                    if (dly_q == '0) begin
                        dom_nxt = (dom_q << 1) | NUM_DOMAINS'(1);
                        if (stage_q == IW'(NUM_DOMAINS - 1)) begin
                            state_nxt = ST_RUN;
                            rdy_nxt   = 1'b1;
                        end else begin
                            stage_nxt = stage_q + IW'(1);
                            dly_nxt   = DW'(STAGE_DELAY - 1);
                        end
                    end else begin
                        dly_nxt = dly_q - DW'(1);
                    end
                end
                ST_RUN: begin
                    if (SOFT_RST_REQ) begin
                        state_nxt = ST_SOFT;
                        hold_nxt  = '0;
                        dom_nxt   = '0;
                        rdy_nxt   = 1'b0;
                    end
                end
                ST_SOFT: begin
                    if (!ack_q) begin
                        if (hold_q == HW'(SOFT_HOLD - 1)) begin
                            ack_nxt = 1'b1;
                        end else begin
                            hold_nxt = hold_q + HW'(1);
                        end
                    end else if (!SOFT_RST_REQ) begin
                        ack_nxt   = 1'b0;
                        state_nxt = ST_RELEASE;
                        stage_nxt = '0;
                        dly_nxt   = '0;
                    end
                end
                default: state_nxt = ST_HOLD;
            endcase
        end
    end

    assign DOMAIN_RESETN = dom_q;
    assign SOFT_RST_ACK  = ack_q;
    assign ALL_READY     = rdy_q;
    assign SEQ_STATE     = state_q;

endmodule

// File: tb/tb_rst_domain_sequencer.sv
// Bench for rst_domain_sequencer: directed scenarios with literal pins, then random traffic vs a timeline model.
module tb_rst_domain_sequencer;

    localparam int ND = 3;
    localparam int SD = 16;
    localparam int LF = 4;
    localparam int SH = 8;
`ifdef RST_SEQ_WDT_EN
    localparam int WDT = 64;
`endif

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          pll_lock = 1'b1;
    logic          req      = 1'b0;
    logic          kick     = 1'b0;
    logic          ack;
    logic          rdy;
    logic [ND-1:0] dom;
    logic [1:0]    st;
`ifdef RST_SEQ_WDT_EN
    logic          wdt_exp;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit done    = 1'b0;

    always #5 clk = ~clk;

    rst_domain_sequencer #(
        .NUM_DOMAINS (ND),
        .STAGE_DELAY (SD),
        .LOCK_FILT   (LF),
        .SOFT_HOLD   (SH)
`ifdef RST_SEQ_WDT_EN
        ,
        .WDT_CYCLES  (WDT)
`endif
    ) dut (
        .FIC_0_CLK        (clk),
        .RESETN_FIC_0_CLK (rst_n),
        .PLL_LOCK         (pll_lock),
        .SOFT_RST_REQ     (req),
`ifdef RST_SEQ_WDT_EN
        .WDT_KICK         (kick),
        .WDT_EXPIRED      (wdt_exp),
`endif
        .SOFT_RST_ACK     (ack),
        .DOMAIN_RESETN    (dom),
        .ALL_READY        (rdy),
        .SEQ_STATE        (st)
    );

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: edge-indexed timeline. Lock history is kept as raw samples; release times are arithmetic on t_R.
    int          edge_n  = 0;
    int          hi_cnt  = 0;
    logic [31:0] phist   = '0;
    int          m_mode  = 0;
    int          m_dom   = 0;
    int          m_ack   = 0;
    int          m_rdy   = 0;
    int          m_exp   = 0;
    int          m_tr    = 0;
    int          m_soft  = 0;
    int          m_ref   = 0;

    task automatic go_hold();
        m_mode = 0;
        m_dom  = 0;
        m_ack  = 0;
        m_rdy  = 0;
    endtask

    task automatic model_step();
        bit ok, lost, rsync, hit;
        int d;
        edge_n++;
        m_exp = 0;
        if (!rst_n) begin
            phist  = '0;
            hi_cnt = 0;
            go_hold();
            return;
        end
        phist = {phist[30:0], pll_lock};
        rsync = (hi_cnt >= 2);
        if (hi_cnt < 2) hi_cnt++;
        ok   = 1'b1;
        lost = 1'b1;
        // The FSM reacts to lock samples taken 3..LF+2 edges ago (sync, filter, register).
        for (int i = 3; i <= LF + 2; i++) begin
            if (phist[i] !== 1'b1) ok = 1'b0;
            if (phist[i] !== 1'b0) lost = 1'b0;
        end
        if (!rsync) begin
            go_hold();
            return;
        end
        hit = 1'b0;
`ifdef RST_SEQ_WDT_EN
        hit = (m_mode == 2) && !kick && (edge_n - m_ref == WDT);
        if (m_mode == 2 && kick) m_ref = edge_n;
`endif
        case (m_mode)
            0: if (ok) begin
                m_mode = 1;
                m_tr   = edge_n + 1;
            end
            1: if (lost) go_hold();
               else begin
                   d = edge_n - m_tr;
                   if (d >= 0 && d % SD == 0) begin
                       m_dom = d / SD + 1;
                       if (m_dom == ND) begin
                           m_mode = 2;
                           m_rdy  = 1;
                           m_ref  = edge_n;
                       end
                   end
               end
            2: if (lost || hit) go_hold();
               else if (req) begin
                   m_mode = 3;
                   m_soft = edge_n;
                   m_dom  = 0;
                   m_rdy  = 0;
               end
            default: if (lost) go_hold();
               else if (m_ack == 0) begin
                   if (edge_n - m_soft == SH) m_ack = 1;
               end else if (!req) begin
                   m_ack  = 0;
                   m_mode = 1;
                   m_tr   = edge_n + 1;
               end
        endcase
        m_exp = hit ? 1 : 0;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (!done) begin
            chk("domain_resetn", int'(dom), (1 << m_dom) - 1);
            chk("all_ready", int'(rdy), m_rdy);
            chk("seq_state", int'(st), m_mode);
            chk("soft_ack", int'(ack), m_ack);
            chk("thermometer", int'(((int'(dom) + 1) & int'(dom)) == 0), 1);
`ifdef RST_SEQ_WDT_EN
            chk("wdt_expired", int'(wdt_exp), m_exp);
`endif
        end
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_state(input int s, input int max_cyc);
        int i;
        i = 0;
        while (int'(st) != s && i < max_cyc) begin
            @(negedge clk);
            i++;
        end
        chk("wait_state", int'(st), s);
    endtask

    initial begin
        int glitch;
        glitch = 0;
        step(10);
        chk("rst_dom", int'(dom), 0);
        chk("rst_state", int'(st), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_rdy", int'(rdy), 0);
        rst_n = 1'b1;

        // Power-up: two sync edges, LF filter edges, one edge to enter RELEASE -> t_R = edge 8.
        step(7);
        chk("pu_e7_state", int'(st), 1);
        chk("pu_e7_dom", int'(dom), 0);
        step(1);
        chk("pu_tr_dom", int'(dom), 1);
        step(15);
        chk("pu_e23_dom", int'(dom), 1);
        step(1);
        chk("pu_e24_dom", int'(dom), 3);
        step(16);
        chk("pu_e40_dom", int'(dom), 7);
        chk("pu_e40_rdy", int'(rdy), 1);
        chk("pu_e40_state", int'(st), 2);

        // Soft reset handshake.
        step(5);
        req = 1'b1;
        step(1);
        chk("sr_dom", int'(dom), 0);
        chk("sr_state", int'(st), 3);
        step(7);
        chk("sr_ack_early", int'(ack), 0);
        step(1);
        chk("sr_ack", int'(ack), 1);
        step(3);
        req = 1'b0;
        step(1);
        chk("sr_ack_drop", int'(ack), 0);
        chk("sr_rel_state", int'(st), 1);
        step(1);
        chk("sr_tr_dom", int'(dom), 1);
        step(16);
        chk("sr_dom2", int'(dom), 3);
        step(16);
        chk("sr_dom3", int'(dom), 7);
        chk("sr_run", int'(st), 2);

        // Three-sample glitch is filtered; four samples is lock loss.
        step(5);
        pll_lock = 1'b0;
        step(3);
        pll_lock = 1'b1;
        step(10);
        chk("gl3_state", int'(st), 2);
        chk("gl3_dom", int'(dom), 7);
        pll_lock = 1'b0;
        step(4);
        pll_lock = 1'b1;
        step(2);
        chk("gl4_before", int'(st), 2);
        step(1);
        chk("gl4_state", int'(st), 0);
        chk("gl4_dom", int'(dom), 0);
        step(5);
        chk("relock_dom", int'(dom), 1);

        // Lock loss at t_R+20 while two domains are out.
        step(19);
        pll_lock = 1'b0;
        step(6);
        chk("mid_dom_before", int'(dom), 3);
        step(1);
        chk("mid_dom", int'(dom), 0);
        chk("mid_state", int'(st), 0);
        pll_lock = 1'b1;

        // Request rising on the lock-loss edge; then held through RELEASE.
        wait_state(2, 300);
        pll_lock = 1'b0;
        step(6);
        req = 1'b1;
        step(1);
        chk("sim_state", int'(st), 0);
        chk("sim_ack", int'(ack), 0);
        pll_lock = 1'b1;
        wait_state(2, 300);
        step(1);
        chk("late_req_soft", int'(st), 3);
        step(12);
        req = 1'b0;
        step(2);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            if (glitch > 0) begin
                pll_lock = 1'b0;
                glitch--;
            end else begin
                pll_lock = 1'b1;
                if ($urandom_range(0, 199) == 0) glitch = int'($urandom_range(1, 8));
            end
            if ($urandom_range(0, 59) == 0) req = ~req;
`ifdef RST_SEQ_WDT_EN
            kick = ($urandom_range(0, 39) == 0);
`endif
            step(1);
        end

        // Asynchronous assertion clears outputs without a clock edge.
        wait_state(2, 300);
        done = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_dom", int'(dom), 0);
        chk("async_rdy", int'(rdy), 0);
        chk("async_ack", int'(ack), 0);
        chk("async_state", int'(st), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
